case_sweep_ctrl: RTL
====================

CASE_SWEEP_CTRL -- requirements
Module: case_sweep_ctrl

Interface
REQ-001 SHALL have parameter SEL_W, default 3: selector code width; the code space is 2**SEL_W.
REQ-002 SHALL have parameter DWELL_W, default 4: width of the dwell count.
REQ-003 SHALL have parameter PASS_W, default 4: width of the pass count.
REQ-004 SHALL have port clk_i, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port start_i, input, 1: start-sweep request, sampled only in IDLE.
REQ-007 SHALL have port abort_i, input, 1: terminates the sweep.
REQ-008 SHALL have port code_mask_i, input, 2**SEL_W: enabled codes; bit n enables code n.
REQ-009 SHALL have port dwell_i, input, DWELL_W: idle cycles inserted after each acknowledged code.
REQ-010 SHALL have port passes_i, input, PASS_W: full sweeps to run; 0 is treated as 1.
REQ-011 SHALL have port sel_o, output, SEL_W: the currently presented code.
REQ-012 SHALL have port sel_valid_o, output, 1: sel_o is valid and awaiting acknowledge.
REQ-013 SHALL have port sel_ack_i, input, 1: the consumer accepts sel_o when both valid and ack are high.
REQ-014 SHALL have port busy_o, output, 1: high in any state other than IDLE.
REQ-015 SHALL have port done_o, output, 1: one-cycle pulse when a sweep ends.
REQ-016 SHALL have port aborted_o, output, 1: qualifies done_o, high when the end was caused by abort.
REQ-017 SHALL have port err_empty_o, output, 1: one-cycle pulse when a start is rejected because the mask is zero.
REQ-018 SHALL have port pass_cnt_o, output, PASS_W: number of completed passes.

Function
REQ-019 SHALL implement the FSM states IDLE, PRESENT, DWELL and DONE.
REQ-020 IDLE, start_i=1, abort_i=0, mask!=0 -> SHALL latch code_mask_i, dwell_i and passes_i, clear pass_cnt_o, load sel_o with the lowest enabled code, and enter PRESENT.
REQ-021 IDLE, start_i=1, mask==0 -> SHALL pulse err_empty_o for one cycle and stay in IDLE.
REQ-022 start_i SHALL be ignored outside IDLE.
REQ-023 In PRESENT, sel_valid_o SHALL be 1, and sel_o SHALL hold stable until acknowledged.
REQ-024 PRESENT, sel_ack_i=1 -> SHALL enter DWELL if the latched dwell is nonzero, else advance directly.
REQ-025 DWELL SHALL last exactly the latched dwell cycles with sel_valid_o=0, then advance.
REQ-026 Advance SHALL select the next enabled code above sel_o, searching cyclically upward.
REQ-027 If the search wraps (next code <= current code, including a single enabled code) -> SHALL increment pass_cnt_o.
REQ-028 When the incremented pass count equals the effective passes value -> SHALL enter DONE instead of PRESENT.
REQ-029 The next-code search SHALL be combinational, with zero added latency per code.
REQ-030 DONE SHALL last one cycle, pulse done_o, and return to IDLE.
REQ-031 abort_i=1 in PRESENT or DWELL -> SHALL enter DONE with aborted_o=1 alongside done_o.
REQ-032 An ack arriving in the same cycle as abort SHALL be consumed, but the sweep SHALL still abort with no advance.
REQ-033 abort_i=1 in IDLE SHALL take priority over start_i, with no state change and no pulse.
REQ-034 Mask and parameter input changes during a sweep SHALL have no effect; the latched copies rule.
REQ-035 Latency from start to first sel_valid_o SHALL be 1 cycle.
REQ-036 With dwell 0 and ack held high, SHALL present one code per cycle.
REQ-037 pass_cnt_o SHALL hold its final value after DONE until the next accepted start.

Reset
REQ-038 rst_ni low SHALL, asynchronously, force state IDLE and drive sel_o=0, sel_valid_o=0, busy_o=0, done_o=0, aborted_o=0, err_empty_o=0, pass_cnt_o=0, and clear all latched copies and the dwell counter.
REQ-039 Reset mid-sweep SHALL produce no done_o pulse.
REQ-040 Operation SHALL resume on the first clock edge after rst_ni deasserts.

Structure
REQ-041 A shared package case_sweep_pkg SHALL hold the state enum type and the default parameter constants.
REQ-042 A sub-module case_sweep_next_code SHALL hold the combinational cyclic next-set-bit search plus its wrap flag.

Verification
REQ-043 Mask 0x37, dwell 0, passes 1, ack always high, start at cycle 0 -> sel_o=0,1,2,4,5 valid in cycles 1-5; done_o=1 in cycle 6; aborted_o=0; pass_cnt_o=1.
REQ-044 Mask 0x80, passes 3, dwell 2 -> code 7 presented 3 times, each followed by 2 dwell cycles; pass_cnt_o steps 1,2,3; then done_o.
REQ-045 Mask 0x00, start -> err_empty_o pulses for 1 cycle; busy_o stays 0.
REQ-046 Mask 0x05, ack held low for 4 cycles -> sel_o=0 with valid held for 4 cycles; after ack, sel_o=2.
REQ-047 Abort asserted in DWELL after code 1 (mask 0xFF) -> next cycle done_o=1 and aborted_o=1; code 2 never presented.
REQ-048 rst_ni asserted while in PRESENT -> all outputs 0 immediately; a following start runs a sweep from code 0.

Source files
------------

// File: rtl/case_sweep_pkg.sv
`default_nettype none
// ============================================================================
// Module      : case_sweep_pkg
// Description : Shared types and default constants for the case sweep
//               controller: state encoding, state enum and parameter defaults.
// Revision    : 1.0 - initial release
// ============================================================================
package case_sweep_pkg;

    // Default widths for the controller parameters
    localparam int SEL_W_DEF   = 3;
    localparam int DWELL_W_DEF = 4;
    localparam int PASS_W_DEF  = 4;

    // Explicit state encodings, kept as plain constants for legacy users
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESENT = 2'd1;
    localparam logic [1:0] ST_DWELL   = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = ST_IDLE,
        S_PRESENT = ST_PRESENT,
        S_DWELL   = ST_DWELL,
        S_DONE    = ST_DONE
    } state_e;

endpackage
`default_nettype wire

// File: rtl/case_sweep_next_code.sv
`default_nettype none
// ============================================================================
// Module      : case_sweep_next_code
// Description : Combinational cyclic next-set-bit search. Returns the lowest
//               enabled code strictly above cur; if none exists, wraps to the
//               lowest enabled code overall and raises wrap. A single enabled
//               code equal to cur therefore always wraps back to itself.
// Revision    : 1.0 - initial release
// ============================================================================
module case_sweep_next_code
    import case_sweep_pkg::*;
#(
    parameter int SEL_W = SEL_W_DEF
) (
    input  logic [2**SEL_W-1:0] mask,
    input  logic [SEL_W-1:0]    cur,
    output logic [SEL_W-1:0]    next_code,
    output logic                wrap
);

    localparam int NCODES = 2**SEL_W;

    logic             w_found_above;
    logic [SEL_W-1:0] w_above;
    logic [SEL_W-1:0] w_lowest;

    // Scan downward so the last hit is the lowest qualifying code
    always_comb begin
        w_found_above = 1'b0;
        w_above       = '0;
        w_lowest      = '0;
        for (int i = NCODES - 1; i >= 0; i--) begin
            if (mask[i]) begin
                w_lowest = SEL_W'(i);
                if (i > int'(cur)) begin
                    w_above       = SEL_W'(i);
                    w_found_above = 1'b1;
                end
            end
        end
    end

    assign next_code = w_found_above ? w_above : w_lowest;
    assign wrap      = ~w_found_above;

endmodule
`default_nettype wire

// File: rtl/case_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : case_sweep_ctrl
// Description : Sweeps through the enabled selector codes in ascending order,
//               presenting each with a valid/ack handshake, inserting optional
//               dwell cycles after each accepted code, and repeating for a
//               programmable number of full passes. Supports abort and
//               rejects starts with an empty mask.
// Revision    : 1.0 - initial release
// ============================================================================
module case_sweep_ctrl
    import case_sweep_pkg::*;
#(
    parameter int SEL_W   = SEL_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF,
    parameter int PASS_W  = PASS_W_DEF
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic [2**SEL_W-1:0] code_mask_i,
    input  logic [DWELL_W-1:0]  dwell_i,
    input  logic [PASS_W-1:0]   passes_i,
    output logic [SEL_W-1:0]    sel_o,
    output logic                sel_valid_o,
    input  logic                sel_ack_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                aborted_o,
    output logic                err_empty_o,
    output logic [PASS_W-1:0]   pass_cnt_o
);

    localparam int NCODES = 2**SEL_W;

    // Registered state and latched sweep configuration
    state_e              r_state;
    logic [NCODES-1:0]   r_mask;
    logic [DWELL_W-1:0]  r_dwell;
    logic [DWELL_W-1:0]  r_dwell_cnt;
    logic [PASS_W-1:0]   r_passes;
    logic [PASS_W-1:0]   r_pass_cnt;
    logic [SEL_W-1:0]    r_sel;
    logic                r_aborted;
    logic                r_err_empty;

    // Combinational helpers
    logic [SEL_W-1:0]    w_next_code;
    logic                w_wrap;
    logic [SEL_W-1:0]    w_first_code;
    logic [PASS_W-1:0]   w_pass_inc;
    logic [PASS_W-1:0]   w_passes_eff;
    logic                w_finish;
    logic                w_in_done;

    // Next enabled code above the one currently presented, from the latched mask
    case_sweep_next_code #(
        .SEL_W     (SEL_W)
    ) u_next_code (
        .mask      (r_mask),
        .cur       (r_sel),
        .next_code (w_next_code),
        .wrap      (w_wrap)
    );

    // Lowest enabled code of the live mask, loaded as the first code on start
    always_comb begin
        w_first_code = '0;
        for (int i = NCODES - 1; i >= 0; i--) begin
            if (code_mask_i[i]) begin
                w_first_code = SEL_W'(i);
            end
        end
    end

    // A requested pass count of zero runs a single pass
    assign w_passes_eff = (passes_i == '0) ? PASS_W'(1) : passes_i;
    assign w_pass_inc   = r_pass_cnt + PASS_W'(1);
    // Advancing ends the sweep when the search wraps on the final pass
    assign w_finish     = w_wrap && (w_pass_inc == r_passes);

    // Main sweep state machine with latched configuration
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_mask      <= '0;
            r_dwell     <= '0;
            r_dwell_cnt <= '0;
            r_passes    <= '0;
            r_pass_cnt  <= '0;
            r_sel       <= '0;
            r_aborted   <= 1'b0;
            r_err_empty <= 1'b0;
        end else begin
            r_err_empty <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Abort in IDLE simply masks a concurrent start
                    if (start_i && !abort_i) begin
                        if (code_mask_i != '0) begin
                            r_mask     <= code_mask_i;
                            r_dwell    <= dwell_i;
                            r_passes   <= w_passes_eff;
                            r_pass_cnt <= '0;
                            r_sel      <= w_first_code;
                            r_aborted  <= 1'b0;
                            r_state    <= S_PRESENT;
                        end else begin
                            r_err_empty <= 1'b1;
                        end
                    end
                end
                S_PRESENT: begin
                    // Abort wins over a coincident ack: the ack is consumed
                    // but no advance happens
                    if (abort_i) begin
                        r_aborted <= 1'b1;
                        r_state   <= S_DONE;
                    end else if (sel_ack_i) begin
                        if (r_dwell != '0) begin
                            r_dwell_cnt <= r_dwell;
                            r_state     <= S_DWELL;
                        end else begin
                            if (w_wrap) begin
                                r_pass_cnt <= w_pass_inc;
                            end
                            if (w_finish) begin
                                r_state <= S_DONE;
                            end else begin
                                r_sel   <= w_next_code;
                                r_state <= S_PRESENT;
                            end
                        end
                    end
                end
                S_DWELL: begin
                    if (abort_i) begin
                        r_aborted <= 1'b1;
                        r_state   <= S_DONE;
                    end else if (r_dwell_cnt == DWELL_W'(1)) begin
                        if (w_wrap) begin
                            r_pass_cnt <= w_pass_inc;
                        end
                        if (w_finish) begin
                            r_state <= S_DONE;
                        end else begin
                            r_sel   <= w_next_code;
                            r_state <= S_PRESENT;
                        end
                    end else begin
                        r_dwell_cnt <= r_dwell_cnt - DWELL_W'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign w_in_done   = (r_state == S_DONE);
    assign sel_o       = r_sel;
    assign sel_valid_o = (r_state == S_PRESENT);
    assign busy_o      = (r_state != S_IDLE);
    assign done_o      = w_in_done;
    assign aborted_o   = w_in_done & r_aborted;
    assign err_empty_o = r_err_empty;
    assign pass_cnt_o  = r_pass_cnt;

endmodule
`default_nettype wire
